// File: rtl/rep16_pkg.sv
// Shared parameters and state type for the 16x repetition encoder.
package rep16_pkg;
   localparam int DATA_W         = 8;
   localparam int CODE_W         = 16;
   localparam int VOTE_THRESHOLD = 9;
   localparam int IDX_W          = $clog2(DATA_W);

   typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/rep16_expand.sv
// Replicates one data bit across a codeword and applies the injection mask.
module rep16_expand
   import rep16_pkg::*;
(
   input  logic              bit_in,
   input  logic [CODE_W-1:0] mask,
   output logic [CODE_W-1:0] code
);
   genvar gi;
   generate
      for (gi = 0; gi < CODE_W; gi++) begin : g_rep
         assign code[gi] = bit_in ^ mask[gi];
      end
   endgenerate
endmodule

// File: rtl/rep16_encoder.sv
// Byte-in, codeword-out serializer: one CODE_W repetition codeword per data bit, MSB first.
module rep16_encoder
   import rep16_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              inj_en,
   input  logic [CODE_W-1:0] inj_mask,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_last,
   output logic              busy
);
   state_t            state_reg, state_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic [CODE_W-1:0] mask_reg, mask_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic              fire;
   logic              load;
   logic [CODE_W-1:0] code;

   assign out_valid = (state_reg == SEND);
   assign busy      = out_valid;
   assign out_last  = out_valid && (idx_reg == '0);
   assign fire      = out_valid && out_ready;
   // Next byte may be taken on the final codeword's handshake, giving bubble-free streaming.
   assign in_ready  = rst_n && ((state_reg == IDLE) || (fire && out_last));
   assign load      = in_valid && in_ready;

   rep16_expand u_expand (
      .bit_in (shift_reg[DATA_W-1]),
      .mask   (mask_reg),
      .code   (code)
   );

   assign out_code = out_valid ? code : '0;

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      mask_next  = mask_reg;
      idx_next   = idx_reg;
      if (load) begin
         state_next = SEND;
         shift_next = in_data;
         mask_next  = inj_en ? inj_mask : '0;
         idx_next   = IDX_W'(DATA_W - 1);
      end else if (fire) begin
         if (out_last) begin
            state_next = IDLE;
         end else begin
            shift_next = {shift_reg[DATA_W-2:0], 1'b0};
            idx_next   = idx_reg - IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         mask_reg  <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         mask_reg  <= mask_next;
         idx_reg   <= idx_next;
      end
   end
endmodule

// File: tb/tb_rep16_encoder.sv
// Self-checking bench for rep16_encoder against a queue-of-codewords reference model.
module tb_rep16_encoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        inj_en = 1'b0;
   logic [15:0] inj_mask = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_code;
   logic        out_last;
   logic        busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] code;
      bit          last;
   } word_t;

   word_t       exp_q[$];
   logic [15:0] obs_codes[$];

   always #5 clk = ~clk;

   rep16_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .inj_en    (inj_en),
      .inj_mask  (inj_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last),
      .busy      (busy)
   );

   // Spec-level model: a byte becomes eight codewords, each the replicated bit XOR the byte's mask.
   task automatic push_byte(input logic [7:0] d, input logic [15:0] m);
      word_t w;
      for (int i = 7; i >= 0; i--) begin
         w.code = (d[i] ? 16'hFFFF : 16'h0000) ^ m;
         w.last = (i == 0);
         exp_q.push_back(w);
      end
   endtask

   function automatic logic exp_in_ready();
      if (!rst_n) return 1'b0;
      if (exp_q.size() == 0) return 1'b1;
      return out_ready && exp_q[0].last;
   endfunction

   function automatic logic [19:0] model_vec();
      logic        v;
      logic [15:0] c;
      logic        l;
      v = (exp_q.size() != 0);
      c = v ? exp_q[0].code : 16'h0000;
      l = v ? exp_q[0].last : 1'b0;
      return {exp_in_ready(), v, l, v, c};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {in_ready, out_valid, out_last, busy, out_code};
   endfunction

   // Majority-of-16 voter decode of eight captured codewords, MSB first.
   function automatic logic [7:0] decode(input int first);
      logic [7:0] b;
      for (int i = 0; i < 8; i++)
         b[7-i] = ($countones(obs_codes[first+i]) >= 9);
      return b;
   endfunction

   task automatic drive(input logic iv, input logic [7:0] d, input logic ie,
                        input logic [15:0] m, input logic ordy);
      in_valid  = iv;
      in_data   = d;
      inj_en    = ie;
      inj_mask  = m;
      out_ready = ordy;
      @(negedge clk);
   endtask

   // Advance one clock; returns whether the model expected a byte to be accepted.
   task automatic advance(output bit accepted);
      bit fire;
      if (out_valid && out_ready) obs_codes.push_back(out_code);
      fire     = (exp_q.size() != 0) && out_ready;
      accepted = in_valid && exp_in_ready();
      @(posedge clk);
      if (fire) void'(exp_q.pop_front());
      if (accepted) push_byte(in_data, inj_en ? inj_mask : 16'h0000);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 8'h55, 1'b0, 16'h0, 1'b1);
      checks++;
      if (dut_vec() !== 20'h0) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", dut_vec(), 20'h0);
      end
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_a5();
      logic [15:0] tab[8] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                              16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
      bit acc;
      obs_codes.delete();
      for (int c = 0; c < 10; c++) begin
         drive(c == 0, 8'hA5, 1'b0, 16'h0, 1'b1);
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL a5_cycle%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         advance(acc);
      end
      checks++;
      if (obs_codes.size() != 8) begin
         failures++;
         $display("FAIL a5_count got=%0d exp=8", obs_codes.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_codes[i] !== tab[i]) begin
               failures++;
               $display("FAIL a5_word%0d got=%h exp=%h", i, obs_codes[i], tab[i]);
            end
         end
      end
   endtask

   task automatic test_inject(input logic [15:0] m, input logic [15:0] first_exp,
                              input logic [7:0] dec_exp);
      bit acc;
      obs_codes.delete();
      for (int c = 0; c < 10; c++) begin
         // Mask inputs scrambled after the first cycle must not affect the byte.
         drive(c == 0, 8'h80, (c == 0) ? 1'b1 : 1'($urandom), (c == 0) ? m : 16'($urandom), 1'b1);
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL inject_%h_cycle%0d got=%h exp=%h", m, c, dut_vec(), model_vec());
         end
         advance(acc);
      end
      checks++;
      if (obs_codes.size() != 8) begin
         failures++;
         $display("FAIL inject_%h_count got=%0d exp=8", m, obs_codes.size());
      end else begin
         checks++;
         if (obs_codes[0] !== first_exp) begin
            failures++;
            $display("FAIL inject_%h_first got=%h exp=%h", m, obs_codes[0], first_exp);
         end
         checks++;
         if (decode(0) !== dec_exp) begin
            failures++;
            $display("FAIL inject_%h_decode got=%h exp=%h", m, decode(0), dec_exp);
         end
      end
   endtask

   task automatic test_backpressure();
      logic        rdy[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [15:0] held;
      bit          acc;
      obs_codes.delete();
      for (int c = 0; c < 12; c++) begin
         drive(c == 0, 8'h3C, 1'b0, 16'h0, rdy[c]);
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL stall_cycle%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         if (c == 2) held = out_code;
         if (c == 3) begin
            checks++;
            if (out_code !== held || in_ready !== 1'b0) begin
               failures++;
               $display("FAIL stall_hold got=%h/%b exp=%h/0", out_code, in_ready, held);
            end
         end
         advance(acc);
      end
      checks++;
      if (obs_codes.size() != 8 || decode(0) !== 8'h3C) begin
         failures++;
         $display("FAIL stall_decode got=%0d words exp=8 words of 3c", obs_codes.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes[2] = '{8'h01, 8'hFE};
      int  idx = 0;
      int  valid_cycles = 0;
      bit  acc;
      obs_codes.delete();
      for (int c = 0; c < 19; c++) begin
         drive(idx < 2, (idx < 2) ? bytes[idx] : 8'h00, 1'b0, 16'h0, 1'b1);
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL b2b_cycle%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         if (out_valid) valid_cycles++;
         advance(acc);
         if (acc) idx++;
      end
      checks++;
      if (valid_cycles != 16 || obs_codes.size() != 16) begin
         failures++;
         $display("FAIL b2b_gapless got=%0d exp=16", valid_cycles);
      end else begin
         checks++;
         if ({decode(0), decode(8)} !== 16'h01FE) begin
            failures++;
            $display("FAIL b2b_decode got=%h exp=01fe", {decode(0), decode(8)});
         end
      end
   endtask

   task automatic test_reset_mid();
      bit acc;
      obs_codes.delete();
      for (int c = 0; c < 4; c++) begin
         drive(c == 0, 8'hFF, 1'b0, 16'h0, 1'b1);
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL rstmid_cycle%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         advance(acc);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if (out_valid !== 1'b0 || dut_vec() !== 20'h0) begin
         failures++;
         $display("FAIL rstmid_async got=%h exp=%h", dut_vec(), 20'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      obs_codes.delete();
      for (int c = 0; c < 10; c++) begin
         drive(c == 0, 8'h00, 1'b0, 16'h0, 1'b1);
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL rstmid_after%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         advance(acc);
      end
      checks++;
      if (obs_codes.size() != 8 || (obs_codes.size() == 8 && decode(0) !== 8'h00)) begin
         failures++;
         $display("FAIL rstmid_zero got=%0d words exp=8 zero words", obs_codes.size());
      end
   endtask

   task automatic test_random();
      bit acc;
      int c = 0;
      int accepted = 0;
      while (accepted < 25 && c < 2000) begin
         drive(($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom),
               16'($urandom), ($urandom_range(0, 3) != 0));
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL random_cycle%0d got=%h exp=%h", c, dut_vec(), model_vec());
         end
         advance(acc);
         if (acc) accepted++;
         c++;
      end
      checks++;
      if (accepted < 25) begin
         failures++;
         $display("FAIL random_budget got=%0d bytes exp=25", accepted);
      end
   endtask

   initial begin
      test_reset();
      test_a5();
      test_inject(16'h007F, 16'hFF80, 8'h80);
      test_inject(16'h00FF, 16'hFF00, 8'h00);
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
